// File: rtl/mul_seq_16_pkg.sv
// Shared ALU constants and the sequential multiplier state encoding.
package mul_seq_16_pkg;

  // Default operand width of the multiplier.
  localparam int unsigned MulWidth = 16;

  // Width of one carry-lookahead slice in the ripple adder.
  localparam int unsigned ClaSliceWidth = 4;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } mul_state_e;

  // The iteration counter must reach WIDTH without wrapping.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/mul_seq_16_if.sv
// Operand/result handshake bundle for the sequential multiplier.
interface mul_seq_16_if import mul_seq_16_pkg::*; #(
  parameter int unsigned WIDTH = MulWidth
);
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               ready;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] p;

  modport master (
    output start, a, b,
    input  ready, busy, done, p
  );

  modport slave (
    input  start, a, b,
    output ready, busy, done, p
  );
endinterface

// File: rtl/add_16.sv
// WIDTH-bit adder: a ripple of 4-bit carry-lookahead slices.
module add_16 import mul_seq_16_pkg::*; #(
  parameter int unsigned WIDTH = MulWidth
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             c_i,
  output logic [WIDTH-1:0] s_o,
  output logic             c_o
);
  localparam int unsigned NumSlices = WIDTH / ClaSliceWidth;

  for (genvar s = 0; s < NumSlices; s++) begin : g_slice
    logic [3:0] g;
    logic [3:0] p;
    logic       ci;
    logic       c1;
    logic       c2;
    logic       c3;
    logic       co;

    // Per-slice carry-in is a separate net so the chain never forms a vector loop.
    if (s == 0) begin : g_first
      assign ci = c_i;
    end else begin : g_rest
      assign ci = g_slice[s-1].co;
    end

    assign g  = a_i[4*s +: 4] & b_i[4*s +: 4];
    assign p  = a_i[4*s +: 4] ^ b_i[4*s +: 4];
    assign c1 = g[0] | (p[0] & ci);
    assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    assign co = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & ci);
    assign s_o[4*s +: 4] = p ^ {c3, c2, c1, ci};
  end

  assign c_o = g_slice[NumSlices-1].co;
endmodule

// File: rtl/mul_seq_16.sv
// Unsigned shift-add multiplier: one product bit per cycle, WIDTH iterations.
module mul_seq_16 import mul_seq_16_pkg::*; #(
  parameter int unsigned WIDTH = MulWidth
) (
  input logic         clk,
  input logic         rst,
  mul_seq_16_if.slave bus
);
  localparam int unsigned CntW = cnt_width(WIDTH);

  mul_state_e         state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [CntW-1:0]    cnt_q, cnt_d;

  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   sum;
  logic               c_out;

  assign addend = prod_q[0] ? mcand_q : '0;

  add_16 #(
    .WIDTH (WIDTH)
  ) u_add (
    .a_i (prod_q[2*WIDTH-1:WIDTH]),
    .b_i (addend),
    .c_i (1'b0),
    .s_o (sum),
    .c_o (c_out)
  );

  // Next-state: load operands when ready, otherwise iterate; the adder carry
  // lands directly in the product's top bit, so no separate carry flop exists.
  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (bus.start) begin
          mcand_d = bus.a;
          prod_d  = {{WIDTH{1'b0}}, bus.b};
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        prod_d = {c_out, sum, prod_q[WIDTH-1:1]};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CntW'(WIDTH - 1)) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset taking priority over start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      mcand_q <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.ready = (state_q == StIdle) || (state_q == StDone);
  assign bus.busy  = (state_q == StRun);
  assign bus.done  = (state_q == StDone);
  assign bus.p     = prod_q;
endmodule
